serial_add_sub: RTL and testbench

//  Bit-serial adder/subtractor built around a single full-adder bit slice and a carry flop.

---
 rtl/serial_add_sub.sv | 81 ++++++++
 tb/tb_serial_add_sub.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_sub.sv
// serial_add_sub: bit-serial adder/subtractor, LSB-first, one full-adder slice plus a carry flop
module serial_add_sub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow,
    output logic             busy,
    output logic             done
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh, b_sh, r_sh, r_next;
    logic [CW-1:0]    cnt;
    logic             carry, s, carry_next, last;

    // single full-adder slice on the current LSBs; sum enters the result shifter at the MSB
    always_comb begin
        s          = a_sh[0] ^ b_sh[0] ^ carry;
        carry_next = (a_sh[0] & b_sh[0]) | (carry & (a_sh[0] ^ b_sh[0]));
        r_next     = (r_sh >> 1) | (WIDTH'(s) << (WIDTH - 1));
        last       = cnt == CW'(WIDTH - 1);
    end

    // control FSM and datapath; on the last bit the carry before update is the carry into the MSB
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            a_sh     <= '0;
            b_sh     <= '0;
            r_sh     <= '0;
            carry    <= 1'b0;
            cnt      <= '0;
            result   <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state <= RUN;
                    busy  <= 1'b1;
                    a_sh  <= a;
                    b_sh  <= b ^ {WIDTH{sub}};
                    carry <= sub;
                    cnt   <= '0;
                end
                RUN: begin
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    r_sh  <= r_next;
                    carry <= carry_next;
                    cnt   <= cnt + 1'b1;
                    if (last) begin
                        state    <= DONE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        result   <= r_next;
                        cout     <= carry_next;
                        overflow <= carry ^ carry_next;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_add_sub.sv
// tb_serial_add_sub: checks WIDTH=8 and WIDTH=1 instances against an arithmetic model plus literal vectors
module tb_serial_add_sub;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start_v[2];
    logic       sub_v[2];
    logic [7:0] a_v[2];
    logic [7:0] b_v[2];
    logic [7:0] res8;
    logic       res1;
    logic       cout8, cout1, ovf8, ovf1, busy8, busy1, done8, done1;

    serial_add_sub #(.WIDTH(8)) d8 (
        .clk(clk), .rst(rst), .start(start_v[0]), .sub(sub_v[0]), .a(a_v[0]), .b(b_v[0]),
        .result(res8), .cout(cout8), .overflow(ovf8), .busy(busy8), .done(done8)
    );

    serial_add_sub #(.WIDTH(1)) d1 (
        .clk(clk), .rst(rst), .start(start_v[1]), .sub(sub_v[1]), .a(a_v[1][0]), .b(b_v[1][0]),
        .result(res1), .cout(cout1), .overflow(ovf1), .busy(busy1), .done(done1)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    int m_phase[2];
    int m_left[2];
    int m_res[2], m_cout[2], m_ovf[2];
    int p_res[2], p_cout[2], p_ovf[2];

    function automatic int wid(int i);
        return i == 0 ? 8 : 1;
    endfunction

    // {busy, done, overflow, cout, result[7:0]}
    function automatic logic [11:0] outs(int i);
        return i == 0 ? {busy8, done8, ovf8, cout8, res8} : {busy1, done1, ovf1, cout1, 7'b0, res1};
    endfunction

    // expected {overflow, cout, result} from plain unsigned/signed arithmetic
    function automatic logic [9:0] calc(int w, int a, int b, bit s);
        int m, half, sa, sb, r, sr;
        bit c, o;
        m    = (1 << w) - 1;
        half = 1 << (w - 1);
        a    = a & m;
        b    = b & m;
        sa   = a >= half ? a - (1 << w) : a;
        sb   = b >= half ? b - (1 << w) : b;
        r    = (s ? a - b : a + b) & m;
        c    = s ? (a >= b) : (a + b > m);
        sr   = s ? sa - sb : sa + sb;
        o    = (sr < -half) || (sr > half - 1);
        return {o, c, r[7:0]};
    endfunction

    task automatic chk(string nm, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // reference model: accept in idle, WIDTH run edges, one done cycle
    always @(posedge clk) begin
        logic [9:0] e;
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_phase[i] = 0;
                m_res[i]   = 0;
                m_cout[i]  = 0;
                m_ovf[i]   = 0;
            end else if (m_phase[i] == 0) begin
                if (start_v[i] === 1'b1) begin
                    e          = calc(wid(i), int'(a_v[i]), int'(b_v[i]), sub_v[i]);
                    p_res[i]   = int'(e[7:0]);
                    p_cout[i]  = int'(e[8]);
                    p_ovf[i]   = int'(e[9]);
                    m_left[i]  = wid(i);
                    m_phase[i] = 1;
                end
            end else if (m_phase[i] == 1) begin
                m_left[i]--;
                if (m_left[i] == 0) begin
                    m_phase[i] = 2;
                    m_res[i]   = p_res[i];
                    m_cout[i]  = p_cout[i];
                    m_ovf[i]   = p_ovf[i];
                end
            end else begin
                m_phase[i] = 0;
            end
        end
    end

    // per-cycle comparison of every output of both instances against the model
    always @(negedge clk) begin
        logic [11:0] o;
        string       pre;
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                o   = outs(i);
                pre = i == 0 ? "w8" : "w1";
                chk({pre, " result"}, int'(o[7:0]), m_res[i]);
                chk({pre, " cout"}, int'(o[8]), m_cout[i]);
                chk({pre, " overflow"}, int'(o[9]), m_ovf[i]);
                chk({pre, " done"}, int'(o[10]), int'(m_phase[i] == 2));
                chk({pre, " busy"}, int'(o[11]), int'(m_phase[i] == 1));
            end
        end
    end

    task automatic issue(int i, int a, int b, bit s);
        start_v[i] = 1'b1;
        a_v[i]     = 8'(a);
        b_v[i]     = 8'(b);
        sub_v[i]   = s;
        @(negedge clk);
        start_v[i] = 1'b0;
        a_v[i]     = 8'($urandom);
        b_v[i]     = 8'($urandom);
        sub_v[i]   = 1'($urandom);
    endtask

    task automatic wait_done(int i, output int lat);
        bit seen;
        seen = 1'b0;
        lat  = -1;
        for (int j = 1; j <= 40 && !seen; j++) begin
            @(negedge clk);
            if (outs(i)[10]) begin
                seen = 1'b1;
                lat  = j;
            end
        end
    endtask

    task automatic run_op(int i, int a, int b, bit s, int er, int ec, int eo, bit lit);
        int          lat;
        logic [11:0] o;
        issue(i, a, b, s);
        wait_done(i, lat);
        chk("latency", lat, wid(i));
        o = outs(i);
        if (lit) begin
            chk("lit result", int'(o[7:0]), er);
            chk("lit cout", int'(o[8]), ec);
            chk("lit overflow", int'(o[9]), eo);
        end
        @(negedge clk);
        chk("done width", int'(outs(i)[10]), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, pulses;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            start_v[i] = 1'b0;
            sub_v[i]   = 1'b0;
            a_v[i]     = 8'h00;
            b_v[i]     = 8'h00;
        end
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        chk("reset w8 outs", int'(outs(0)), 0);
        chk("reset w1 outs", int'(outs(1)), 0);
        rst = 1'b0;
        @(negedge clk);

        run_op(0, 8'h05, 8'h03, 1'b0, 8'h08, 0, 0, 1'b1);
        run_op(0, 8'h7F, 8'h01, 1'b0, 8'h80, 0, 1, 1'b1);
        run_op(0, 8'hFF, 8'h01, 1'b0, 8'h00, 1, 0, 1'b1);
        run_op(0, 8'h03, 8'h05, 1'b1, 8'hFE, 0, 0, 1'b1);
        run_op(0, 8'h80, 8'h01, 1'b1, 8'h7F, 1, 1, 1'b1);
        run_op(0, 8'h00, 8'h00, 1'b1, 8'h00, 1, 0, 1'b1);

        issue(0, 8'h10, 8'h20, 1'b0);
        repeat (2) @(negedge clk);
        start_v[0] = 1'b1;
        a_v[0]     = 8'hAA;
        b_v[0]     = 8'h11;
        sub_v[0]   = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        wait_done(0, lat);
        chk("ignored start latency", lat, 5);
        chk("ignored start result", int'(res8), 8'h30);
        pulses = lat > 0 ? 1 : 0;
        repeat (12) begin
            @(negedge clk);
            pulses += int'(done8);
        end
        chk("single done pulse", pulses, 1);

        issue(0, 8'h55, 8'h22, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrun reset w8 outs", int'(outs(0)), 0);
        rst = 1'b0;
        run_op(0, 8'h01, 8'h01, 1'b0, 8'h02, 0, 0, 1'b1);

        run_op(1, 1, 1, 1'b0, 0, 1, 1, 1'b1);
        run_op(1, 1, 1, 1'b1, 0, 1, 0, 1'b1);
        run_op(1, 0, 1, 1'b1, 1, 0, 1, 1'b1);
        run_op(1, 0, 0, 1'b0, 0, 0, 0, 1'b1);

        for (int n = 0; n < 24; n++)
            run_op(0, int'($urandom_range(255)), int'($urandom_range(255)), 1'($urandom), 0, 0, 0, 1'b0);
        for (int n = 0; n < 16; n++)
            run_op(1, int'($urandom_range(1)), int'($urandom_range(1)), 1'($urandom), 0, 0, 0, 1'b0);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
